ntt_operand_feeder: RTL and testbench

//   Upstream sequencer for the radix butterfly datapath (mult_mod_block + butterfly_block).

---
 rtl/ntt_pkg.sv | 33 +++
 rtl/ntt_feed_fifo.sv | 54 +++++
 rtl/ntt_operand_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_ntt_operand_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT operand feeder: default word width, FSM encoding, index math.
// Pure combinational helpers; no latency of their own.
// No flow control here; callers own backpressure.
package ntt_pkg;

  localparam int WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } feed_state_t;

  // Lower butterfly index: insert a zero at bit position s of the pair counter.
  function automatic logic [31:0] pair_i1(input logic [31:0] p, input logic [31:0] s);
    logic [31:0] k;
    k = p & ((32'd1 << s) - 32'd1);
    return ((p >> s) << (s + 32'd1)) | k;
  endfunction

  // Upper butterfly index: same position with bit s set.
  function automatic logic [31:0] pair_i2(input logic [31:0] i1, input logic [31:0] s);
    return i1 | (32'd1 << s);
  endfunction

  // Twiddle ROM index: low s bits of the pair counter, scaled to the full table.
  function automatic logic [31:0] tw_index(input logic [31:0] p, input logic [31:0] s,
                                           input logic [31:0] log_n);
    return (p & ((32'd1 << s) - 32'd1)) << (log_n - 32'd1 - s);
  endfunction

endpackage

// File: rtl/ntt_feed_fifo.sv
// Two-entry valid/ready FIFO carrying one packed beat per entry.
// Latency: one cycle from push to head visibility.
// Backpressure: push_rdy drops only when full and the head is not being popped.
module ntt_feed_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  output logic          push_rdy,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [DW-1:0] pop_dat,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign pop_vld  = (count != 2'd0);
  assign push_rdy = (count != 2'd2) || pop_rdy;
  assign do_push  = push && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push/pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ntt_operand_feeder.sv
// Walks every stage of an in-place bit-reversed NTT, reading operand pairs and twiddles.
// Latency: two cycles from accepted start to first out_valid; one beat per cycle sustained.
// Backpressure: reads are issued only while a FIFO slot is guaranteed, so no beat is ever lost.
module ntt_operand_feeder
  import ntt_pkg::*;
#(
  parameter int          WIDTH = WIDTH_DEF,
  parameter int          LOG_N = 8,
  parameter int unsigned ONE   = 1,
  localparam int         SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stage_ack,
  output logic             busy,
  output logic             done,
  output logic             coef_rd_en,
  output logic [LOG_N-1:0] coef_addr_a,
  output logic [LOG_N-1:0] coef_addr_b,
  input  logic [WIDTH-1:0] coef_data_a,
  input  logic [WIDTH-1:0] coef_data_b,
  output logic             tw_rd_en,
  output logic [LOG_N-2:0] tw_addr,
  input  logic [WIDTH-1:0] tw_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] input_1,
  output logic [WIDTH-1:0] input_2,
  output logic [WIDTH-1:0] weight_1,
  output logic [WIDTH-1:0] weight_2,
  output logic [LOG_N-1:0] out_i1,
  output logic [LOG_N-1:0] out_i2,
  output logic [SW-1:0]    out_stage,
  output logic             out_last
);

  localparam int PW = LOG_N - 1;

  typedef struct packed {
    logic [LOG_N-1:0] i1;
    logic [LOG_N-1:0] i2;
    logic [SW-1:0]    stage;
    logic             last;
  } meta_t;

  typedef struct packed {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] w2;
    meta_t            meta;
  } beat_t;

  feed_state_t      state;
  logic [SW-1:0]    stage;
  logic [PW-1:0]    pair;
  logic             inflight;
  meta_t            meta_q;

  logic [31:0]      i1_full;
  logic [31:0]      i2_full;
  logic [31:0]      tw_full;
  logic [LOG_N-1:0] i1_c;
  logic [LOG_N-1:0] i2_c;
  logic [PW-1:0]    tw_c;
  logic             last_pair;

  logic [1:0]       fifo_count;
  logic             fifo_vld;
  logic             fifo_push_rdy;
  logic             pop;
  logic [1:0]       outstanding;
  logic             issue;
  beat_t            push_beat;
  beat_t            head;
  logic             unused_bits;

  // Pair and twiddle indices for the current (stage, pair) position.
  always_comb begin
    i1_full = pair_i1(32'(pair), 32'(stage));
    i2_full = pair_i2(i1_full, 32'(stage));
    tw_full = tw_index(32'(pair), 32'(stage), 32'(LOG_N));
  end

  assign i1_c      = i1_full[LOG_N-1:0];
  assign i2_c      = i2_full[LOG_N-1:0];
  assign tw_c      = tw_full[PW-1:0];
  assign last_pair = &pair;

  assign unused_bits = ^{i1_full[31:LOG_N], i2_full[31:LOG_N], tw_full[31:PW], fifo_push_rdy};

  // A beat leaving the FIFO this cycle frees its slot for a read issued now, which is
  // what lets a 2-entry FIFO with a 1-cycle read sustain one beat per cycle.
  assign pop         = fifo_vld && out_ready;
  assign outstanding = fifo_count + {1'b0, inflight} - {1'b0, pop};
  assign issue       = (state == ST_RUN) && (outstanding < 2'd2);

  assign coef_rd_en  = issue;
  assign tw_rd_en    = issue;
  assign coef_addr_a = issue ? i1_c : '0;
  assign coef_addr_b = issue ? i2_c : '0;
  assign tw_addr     = issue ? tw_c : '0;

  // Metadata travels alongside the one-cycle memory read so it lines up with returned data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      meta_q   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        meta_q <= '{i1: i1_c, i2: i2_c, stage: stage, last: last_pair};
      end
    end
  end

  // Returned read data joined with its metadata forms the beat pushed into the FIFO.
  always_comb begin
    push_beat      = '0;
    push_beat.in1  = coef_data_a;
    push_beat.in2  = coef_data_b;
    push_beat.w2   = tw_data;
    push_beat.meta = meta_q;
  end

  ntt_feed_fifo #(
    .DW($bits(beat_t))
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_dat (push_beat),
    .push_rdy (fifo_push_rdy),
    .pop_vld  (fifo_vld),
    .pop_rdy  (out_ready),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  // Sequencer: stage/pair walk, drain, and the stage barrier on stage_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      stage <= '0;
      pair  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            stage <= '0;
            pair  <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_pair) begin
              state <= ST_DRAIN;
            end else begin
              pair <= pair + PW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!inflight && (fifo_count == 2'd0)) begin
            state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (stage_ack) begin
            pair <= '0;
            if (stage == SW'(LOG_N - 1)) begin
              state <= ST_IDLE;
              stage <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              stage <= stage + SW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO head drives the stream; payload reads as zero while nothing is presented.
  always_comb begin
    out_valid = fifo_vld;
    weight_1  = WIDTH'(ONE);
    input_1   = '0;
    input_2   = '0;
    weight_2  = '0;
    out_i1    = '0;
    out_i2    = '0;
    out_stage = '0;
    out_last  = 1'b0;
    if (fifo_vld) begin
      input_1   = head.in1;
      input_2   = head.in2;
      weight_2  = head.w2;
      out_i1    = head.meta.i1;
      out_i2    = head.meta.i2;
      out_stage = head.meta.stage;
      out_last  = head.meta.last;
    end
  end

endmodule

// File: tb/tb_ntt_operand_feeder.sv
// Directed bench for ntt_operand_feeder with N=8: RAM[i]=i, ROM[t]=100+t.
// Sequence: reset, plain run, stalled stream, late acks, mid-run reset, start while busy.
// Memories answer one cycle after the read strobe, like the real RAM/ROM.
module tb_ntt_operand_feeder;

  localparam int WIDTH = 18;
  localparam int LOG_N = 3;
  localparam int SW    = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stage_ack;
  logic             busy;
  logic             done;
  logic             coef_rd_en;
  logic [LOG_N-1:0] coef_addr_a;
  logic [LOG_N-1:0] coef_addr_b;
  logic [WIDTH-1:0] coef_data_a;
  logic [WIDTH-1:0] coef_data_b;
  logic             tw_rd_en;
  logic [LOG_N-2:0] tw_addr;
  logic [WIDTH-1:0] tw_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] input_1;
  logic [WIDTH-1:0] input_2;
  logic [WIDTH-1:0] weight_1;
  logic [WIDTH-1:0] weight_2;
  logic [LOG_N-1:0] out_i1;
  logic [LOG_N-1:0] out_i2;
  logic [SW-1:0]    out_stage;
  logic             out_last;

  int errors = 0;
  int checks = 0;
  int issued;
  int accepted;
  int done_cnt = 0;

  // Hand-computed butterfly pairs and twiddle words per stage.
  int exp_i1 [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
  int exp_i2 [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
  int exp_w  [3][4] = '{'{100, 100, 100, 100}, '{100, 102, 100, 102}, '{100, 101, 102, 103}};

  ntt_operand_feeder #(
    .WIDTH (WIDTH),
    .LOG_N (LOG_N),
    .ONE   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stage_ack   (stage_ack),
    .busy        (busy),
    .done        (done),
    .coef_rd_en  (coef_rd_en),
    .coef_addr_a (coef_addr_a),
    .coef_addr_b (coef_addr_b),
    .coef_data_a (coef_data_a),
    .coef_data_b (coef_data_b),
    .tw_rd_en    (tw_rd_en),
    .tw_addr     (tw_addr),
    .tw_data     (tw_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .input_1     (input_1),
    .input_2     (input_2),
    .weight_1    (weight_1),
    .weight_2    (weight_2),
    .out_i1      (out_i1),
    .out_i2      (out_i2),
    .out_stage   (out_stage),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient RAM holding RAM[i]=i and twiddle ROM holding 100+t, one-cycle read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_data_a <= '0;
      coef_data_b <= '0;
      tw_data     <= '0;
    end else begin
      if (coef_rd_en) begin
        coef_data_a <= WIDTH'(coef_addr_a);
        coef_data_b <= WIDTH'(coef_addr_b);
      end
      if (tw_rd_en) begin
        tw_data <= WIDTH'(32'd100 + 32'(tw_addr));
      end
    end
  end

  // Reads issued and beats accepted since reset; their difference is what is outstanding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued   <= 0;
      accepted <= 0;
    end else begin
      if (coef_rd_en) issued <= issued + 1;
      if (out_valid && out_ready) accepted <= accepted + 1;
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, coef_rd_en, tw_rd_en, out_valid, coef_addr_a, coef_addr_b,
                               tw_addr, out_i1, out_i2, out_stage, out_last}), 64'd0);
    check({tag, "_data"}, 64'({input_1, input_2, weight_2}), 64'd0);
    check({tag, "_w1"}, 64'(weight_1), 64'd1);
  endtask

  // mode 0: out_ready always 1; mode 1: 1010 for four cycles, 0 for ten, then 1.
  task automatic run_stage(input int st, input int mode, input int max_beats, input bit ack_in_run,
                           output int first);
    int          idx;
    int          cyc;
    int          outst;
    bit          stalled;
    logic [63:0] held_m;
    logic [63:0] held_d;
    logic [63:0] cur_m;
    logic [63:0] cur_d;
    logic [63:0] exp_m;
    logic [63:0] exp_d;
    idx = 0; cyc = 0; stalled = 1'b0; first = -1; held_m = '0; held_d = '0;
    while (idx < max_beats && cyc < 200) begin
      @(negedge clk);
      if (mode == 0)     out_ready = 1'b1;
      else if (cyc < 4)  out_ready = (cyc % 2 == 0);
      else if (cyc < 14) out_ready = 1'b0;
      else               out_ready = 1'b1;
      stage_ack = ack_in_run && (cyc == 0);
      #1;
      cur_m = 64'({out_stage, out_i1, out_i2, out_last});
      cur_d = 64'({input_1, input_2, weight_2});
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_meta", cur_m, held_m);
        check("stall_data", cur_d, held_d);
      end
      outst = issued - accepted - ((out_valid && out_ready) ? 1 : 0);
      if (outst >= 2) check("credit_block", 64'(coef_rd_en), 64'd0);
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        exp_m = 64'({2'(st), 3'(exp_i1[st][idx]), 3'(exp_i2[st][idx]), (idx == 3)});
        exp_d = 64'({18'(exp_i1[st][idx]), 18'(exp_i2[st][idx]), 18'(exp_w[st][idx])});
        check("beat_meta", cur_m, exp_m);
        check("beat_data", cur_d, exp_d);
        idx++;
      end
      stalled = out_valid && !out_ready;
      held_m  = cur_m;
      held_d  = cur_d;
      cyc++;
    end
    stage_ack = 1'b0;
    check("stage_beats", 64'(idx), 64'(max_beats));
  endtask

  // Stage barrier window: no reads may be issued before the ack.
  task automatic wait_idle(input int delay, input bit start_pulse);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      start = start_pulse && (i == 1);
      #1;
      check("barrier_rd", 64'(coef_rd_en), 64'd0);
    end
    start = 1'b0;
  endtask

  task automatic do_ack(input bit final_stage);
    @(negedge clk);
    stage_ack = 1'b1;
    @(negedge clk);
    stage_ack = 1'b0;
    #1;
    check("done_pulse", 64'(done), 64'(final_stage));
    check("busy_after_ack", 64'(busy), 64'(!final_stage));
    if (final_stage) begin
      @(negedge clk);
      #1;
      check("done_single", 64'(done), 64'd0);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_on_start", 64'(busy), 64'd1);
    check("first_issue", 64'({coef_rd_en, tw_rd_en, coef_addr_a, coef_addr_b, tw_addr}),
          64'({1'b1, 1'b1, 3'd0, 3'd1, 2'd0}));
  endtask

  task automatic do_transform(input int mode, input int delay, input bit start_pulse,
                              input bit ack_in_run);
    int first;
    int base_acc;
    base_acc = accepted;
    start_run();
    for (int st = 0; st < 3; st++) begin
      run_stage(st, mode, 4, ack_in_run && (st == 0), first);
      if (st == 0 && mode == 0) check("first_valid_lat", 64'(first), 64'd1);
      wait_idle(delay, start_pulse);
      do_ack(st == 2);
    end
    check("beat_total", 64'(accepted - base_acc), 64'd12);
  endtask

  initial begin
    int first;
    int dcnt;
    rst_n     = 1'b0;
    start     = 1'b0;
    stage_ack = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("idle");

    // Plain transform with out_ready high and prompt acks.
    do_transform(0, 2, 1'b0, 1'b0);

    // Stalled stream: toggling then held-low out_ready.
    do_transform(1, 2, 1'b0, 1'b0);

    // Late acks (20 cycles) and a stage_ack pulse while running stage 0.
    do_transform(0, 20, 1'b0, 1'b1);

    // Reset in the middle of stage 1.
    start_run();
    run_stage(0, 0, 4, 1'b0, first);
    wait_idle(2, 1'b0);
    do_ack(1'b0);
    run_stage(1, 0, 2, 1'b0, first);
    dcnt = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("no_done_after_rst", 64'(done_cnt), 64'(dcnt));
    check("idle_after_rst", 64'({busy, out_valid, coef_rd_en}), 64'd0);
    do_transform(0, 2, 1'b0, 1'b0);

    // start pulsed while busy must not disturb the sequence.
    do_transform(0, 3, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("final_idle", 64'({busy, done, out_valid, coef_rd_en}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
